// File: rtl/alu_div.sv
// rtl/alu_div.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
module alu_div #(
  parameter int DSIZE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [DSIZE-1:0] quot,
  output logic [DSIZE-1:0] rem,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int CW = $clog2(DSIZE + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [DSIZE-1:0] dvd;      // dividend shifting out at the top, quotient shifting in at the bottom
  logic [DSIZE-1:0] dvs;
  logic [DSIZE:0]   prem;     // partial remainder, one extra bit so the shift never overflows
  logic [CW-1:0]    cnt;

  logic [DSIZE:0]   shifted;
  logic [DSIZE:0]   trial;
  logic [DSIZE:0]   nxt_rem;
  logic [DSIZE-1:0] nxt_q;

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore
  always_comb begin
    shifted = (prem << 1) | {{DSIZE{1'b0}}, dvd[DSIZE-1]};
    trial   = shifted - {1'b0, dvs};
    nxt_rem = trial[DSIZE] ? shifted : trial;
    nxt_q   = {dvd[DSIZE-2:0], ~trial[DSIZE]};
  end

  // Control FSM with datapath and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (b == '0) begin
              // Division by zero completes immediately without iterating
              quot        <= '1;
              rem         <= a;
              zero        <= 1'b0;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else begin
              dvd   <= a;
              dvs   <= b;
              prem  <= '0;
              cnt   <= CW'(DSIZE);
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          dvd  <= nxt_q;
          prem <= nxt_rem;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quot        <= nxt_q;
            rem         <= nxt_rem[DSIZE-1:0];
            zero        <= (nxt_q == '0);
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div.sv
// tb/tb_alu_div.sv - directed and random self-checking bench for alu_div
module tb_alu_div;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] quot;
  logic [15:0] rem;
  logic        zero;
  logic        div_by_zero;

  int n_vec;
  int n_bad;

  alu_div #(.DSIZE(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .quot       (quot),
    .rem        (rem),
    .zero       (zero),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Called at the first falling edge after the sampling rising edge; stops on done
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_div(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic ez, input logic edz);
    int lat, bcnt;
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".lat"}, lat, edz ? 1 : 17);
    chk({tag, ".busycyc"}, bcnt, edz ? 0 : 16);
    chk({tag, ".busy_at_done"}, busy, 0);
    chk({tag, ".quot"}, quot, eq);
    chk({tag, ".rem"}, rem, er);
    chk({tag, ".zero"}, zero, ez);
    chk({tag, ".dbz"}, div_by_zero, edz);
    @(negedge clk);
    chk({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    int lat, bcnt, ndone;
    logic [15:0] ra, rb;
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.quot", quot, 0);
    chk("rst.rem", rem, 0);
    chk("rst.zero", zero, 0);
    chk("rst.dbz", div_by_zero, 0);
    rst_n = 1'b1;

    do_div("basic", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0);
    do_div("small", 16'd5, 16'd9, 16'd0, 16'd5, 1'b1, 1'b0);
    do_div("by1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 1'b0);
    do_div("same", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 1'b0);
    do_div("dbz", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b0, 1'b1);
    do_div("after_dbz", 16'd10, 16'd3, 16'd3, 16'd1, 1'b0, 1'b0);

    // Start while busy is ignored
    @(negedge clk);
    a = 16'd50; b = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 16'd9; b = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("ign.lat", lat, 13);
    chk("ign.quot", quot, 16'd10);
    chk("ign.rem", rem, 16'd0);
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ign.extra_done", ndone, 0);

    // Back-to-back: start held, second operands present on the first done cycle
    a = 16'd50; b = 16'd5; start = 1'b1;
    @(negedge clk);
    a = 16'd77; b = 16'd8;
    wait_done(lat, bcnt);
    chk("b2b1.lat", lat, 17);
    chk("b2b1.quot", quot, 16'd10);
    chk("b2b1.rem", rem, 16'd0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b.busy_again", busy, 1);
    wait_done(lat, bcnt);
    chk("b2b2.lat", lat, 17);
    chk("b2b2.busycyc", bcnt, 16);
    chk("b2b2.quot", quot, 16'd9);
    chk("b2b2.rem", rem, 16'd5);

    // Reset in the middle of an operation
    @(negedge clk);
    a = 16'd100; b = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst.busy", busy, 0);
    chk("mrst.quot", quot, 0);
    chk("mrst.rem", rem, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mrst.no_done", ndone, 0);
    do_div("post_rst", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0);

    // Random pairs with nonzero divisor: check the division identity
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = (i % 3 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
      @(negedge clk);
      a = ra; b = rb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bcnt);
      chk("rnd.ident", {16'd0, quot} * {16'd0, rb} + {16'd0, rem}, {16'd0, ra});
      chk("rnd.rem_lt_b", {31'd0, rem < rb}, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
